// File: rtl/owt_pkg.sv
// Shared one-wire (OWT) definitions used by the HV transmitter and the LV receiver:
// FSM state encoding, frame constants and the serial CRC8 step.
package owt_pkg;

  localparam int OWT_EXT_CYC_W = 8;
  localparam int OWT_SYNC_W    = 12;
  localparam int OWT_TAIL_W    = 4;
  localparam int OWT_CMD_W     = 8;
  localparam int OWT_DATA_W    = 8;
  localparam int OWT_ADCD_W    = 10;
  localparam int OWT_CRC_W     = 8;

  localparam logic [3:0] OWT_TAIL_PAT   = 4'b1100;
  localparam logic [6:0] OWT_ADC_RD_CMD = 7'h1f;
  localparam logic [7:0] OWT_CRC_POLY   = 8'h07;

  typedef enum logic [2:0] {
    IDLE, SYNC_HEAD, SYNC_TAIL, CMD, ADC_DATA, NML_DATA, CRC, END_TAIL
  } owt_state_e;

  // One bit of CRC8, MSB-first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ d) ? OWT_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/owt_crc8_serial.sv
// Bit-serial CRC8 accumulator; i_new_calc restarts from the zero seed on the bit it qualifies.
module owt_crc8_serial
  import owt_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vld,
  input  logic       i_data,
  input  logic       i_new_calc,
  output logic [7:0] o_crc
);

  always_ff @(posedge i_clk) begin
    if (i_rst)      o_crc <= '0;
    else if (i_vld) o_crc <= crc8_step(i_new_calc ? 8'h00 : o_crc, i_data);
  end

endmodule

// File: rtl/hv_owt_tx_ctrl.sv
// HV-side OWT frame transmitter: Manchester-serialises sync, cmd, data/ADC data, CRC8 and tails.
// Optional OWT_TX_CRC_ERR_INJ_EN adds i_owt_tx_crc_err_inj to flip the transmitted CRC LSB.
module hv_owt_tx_ctrl
  import owt_pkg::*;
#(
  parameter int OWT_EXT_CYC_NUM  = OWT_EXT_CYC_W,
  parameter int OWT_SYNC_BIT_NUM = OWT_SYNC_W,
  parameter int OWT_TAIL_BIT_NUM = OWT_TAIL_W,
  parameter int OWT_CMD_BIT_NUM  = OWT_CMD_W,
  parameter int OWT_DATA_BIT_NUM = OWT_DATA_W,
  parameter int OWT_ADCD_BIT_NUM = OWT_ADCD_W,
  parameter int OWT_CRC_BIT_NUM  = OWT_CRC_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_owt_tx_req,
  input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
  input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_tx_data,
  input  logic [OWT_ADCD_BIT_NUM-1:0] i_owt_tx_adcd,
`ifdef OWT_TX_CRC_ERR_INJ_EN
  input  logic                        i_owt_tx_crc_err_inj,
`endif
  output logic                        o_owt_tx_busy,
  output logic                        o_owt_tx_done,
  output logic                        o_hv_lv_owt_tx
);

  localparam int SHW0 = (OWT_CMD_BIT_NUM > OWT_ADCD_BIT_NUM) ? OWT_CMD_BIT_NUM : OWT_ADCD_BIT_NUM;
  localparam int SHW1 = (SHW0 > OWT_CRC_BIT_NUM) ? SHW0 : OWT_CRC_BIT_NUM;
  localparam int SHW  = (SHW1 > OWT_TAIL_BIT_NUM) ? SHW1 : OWT_TAIL_BIT_NUM;
  localparam int HBW  = $clog2(OWT_EXT_CYC_NUM);
  localparam int BCW  = 8;
  localparam logic [HBW-1:0] HB_LAST = HBW'(OWT_EXT_CYC_NUM - 1);

  owt_state_e                  state, state_nxt;
  logic [HBW-1:0]              hb_cnt;
  logic                        half;
  logic [BCW-1:0]              bit_cnt, last_bit;
  logic [SHW-1:0]              sh, sh_load;
  logic [OWT_CMD_BIT_NUM-1:0]  cmd_q;
  logic [OWT_DATA_BIT_NUM-1:0] data_q;
  logic [OWT_ADCD_BIT_NUM-1:0] adcd_q;
  logic                        adc_q, inj_q;
  logic                        accept, manch, sym_end, last_sym, line_c;
  logic                        crc_vld, crc_new;
  logic [7:0]                  crc;

  assign accept = (state == IDLE) && i_owt_tx_req;

`ifdef OWT_TX_CRC_ERR_INJ_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)       inj_q <= 1'b0;
    else if (accept) inj_q <= i_owt_tx_crc_err_inj;
  end
`else
  assign inj_q = 1'b0;
`endif

  // Tail states send one raw symbol per EXT clocks; the rest are two Manchester halves per bit.
  assign manch    = (state == SYNC_HEAD) || (state == CMD) || (state == ADC_DATA) ||
                    (state == NML_DATA)  || (state == CRC);
  assign sym_end  = (hb_cnt == HB_LAST) && (half || !manch);
  assign last_sym = sym_end && (bit_cnt == last_bit);

  always_comb begin
    last_bit = '0;
    case (state)
      SYNC_HEAD:           last_bit = BCW'(OWT_SYNC_BIT_NUM - 1);
      SYNC_TAIL, END_TAIL: last_bit = BCW'(OWT_TAIL_BIT_NUM - 1);
      CMD:                 last_bit = BCW'(OWT_CMD_BIT_NUM - 1);
      ADC_DATA:            last_bit = BCW'(OWT_ADCD_BIT_NUM - 1);
      NML_DATA:            last_bit = BCW'(OWT_DATA_BIT_NUM - 1);
      CRC:                 last_bit = BCW'(OWT_CRC_BIT_NUM - 1);
      default:             last_bit = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (i_owt_tx_req) state_nxt = SYNC_HEAD;
      SYNC_HEAD: if (last_sym) state_nxt = SYNC_TAIL;
      SYNC_TAIL: if (last_sym) state_nxt = CMD;
      CMD:       if (last_sym) state_nxt = adc_q ? ADC_DATA : NML_DATA;
      ADC_DATA:  if (last_sym) state_nxt = CRC;
      NML_DATA:  if (last_sym) state_nxt = CRC;
      CRC:       if (last_sym) state_nxt = END_TAIL;
      END_TAIL:  if (last_sym) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Each field is loaded MSB-aligned into one shift register on state entry.
  always_comb begin
    sh_load = '0;
    case (state_nxt)
      SYNC_TAIL, END_TAIL: sh_load = SHW'(OWT_TAIL_PAT) << (SHW - OWT_TAIL_BIT_NUM);
      CMD:                 sh_load = SHW'(cmd_q) << (SHW - OWT_CMD_BIT_NUM);
      ADC_DATA:            sh_load = SHW'(adcd_q) << (SHW - OWT_ADCD_BIT_NUM);
      NML_DATA:            sh_load = SHW'(data_q) << (SHW - OWT_DATA_BIT_NUM);
      CRC:                 sh_load = SHW'({crc[7:1], crc[0] ^ inj_q}) << (SHW - OWT_CRC_BIT_NUM);
      default:             sh_load = '0;
    endcase
  end

  always_comb begin
    line_c = 1'b0;
    case (state)
      IDLE:                line_c = 1'b0;
      SYNC_HEAD:           line_c = ~half;
      SYNC_TAIL, END_TAIL: line_c = sh[SHW-1];
      default:             line_c = ~(sh[SHW-1] ^ half);
    endcase
  end

  // CRC sees each cmd/data bit once, on the first clock of the bit.
  assign crc_vld = ((state == CMD) || (state == ADC_DATA) || (state == NML_DATA)) &&
                   (hb_cnt == '0) && !half;
  assign crc_new = (state == CMD) && (bit_cnt == '0);

  owt_crc8_serial u_crc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_vld      (crc_vld),
    .i_data     (sh[SHW-1]),
    .i_new_calc (crc_new),
    .o_crc      (crc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      hb_cnt         <= '0;
      half           <= 1'b0;
      bit_cnt        <= '0;
      sh             <= '0;
      cmd_q          <= '0;
      data_q         <= '0;
      adcd_q         <= '0;
      adc_q          <= 1'b0;
      o_owt_tx_busy  <= 1'b0;
      o_owt_tx_done  <= 1'b0;
      o_hv_lv_owt_tx <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_owt_tx_busy  <= (state_nxt != IDLE);
      o_owt_tx_done  <= (state == END_TAIL) && (state_nxt == IDLE);
      o_hv_lv_owt_tx <= line_c;
      if (accept) begin
        cmd_q  <= i_owt_tx_cmd;
        data_q <= i_owt_tx_data;
        adcd_q <= i_owt_tx_adcd;
        adc_q  <= ~i_owt_tx_cmd[OWT_CMD_BIT_NUM-1] && (i_owt_tx_cmd[6:0] == OWT_ADC_RD_CMD);
      end
      if (state_nxt != state) begin
        hb_cnt  <= '0;
        half    <= 1'b0;
        bit_cnt <= '0;
        sh      <= sh_load;
      end else if (state != IDLE) begin
        if (hb_cnt == HB_LAST) begin
          hb_cnt <= '0;
          if (manch) half <= ~half;
          if (sym_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            sh      <= sh << 1;
          end
        end else begin
          hb_cnt <= hb_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hv_owt_tx_ctrl.sv
// Directed bench for hv_owt_tx_ctrl: samples the wire every clock and decodes each frame field.
module tb_hv_owt_tx_ctrl;

  localparam int EXT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] cmd;
  logic [7:0] data;
  logic [9:0] adcd;
  logic       crc_inj;
  logic       busy, done, line;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hv_owt_tx_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_owt_tx_req   (req),
    .i_owt_tx_cmd   (cmd),
    .i_owt_tx_data  (data),
    .i_owt_tx_adcd  (adcd),
`ifdef OWT_TX_CRC_ERR_INJ_EN
    .i_owt_tx_crc_err_inj (crc_inj),
`endif
    .o_owt_tx_busy  (busy),
    .o_owt_tx_done  (done),
    .o_hv_lv_owt_tx (line)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [9:0] d, input int nd);
    logic [7:0] r = 8'h00;
    logic       fb;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ c[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    for (int i = nd - 1; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Send one frame, capture line/busy/done each clock, then decode and check every field.
  task automatic run_frame(input string nm, input logic [7:0] c, input logic [7:0] d,
                           input logic [9:0] a, input logic inj, input int second_at,
                           input logic [7:0] crc_hand, input logic use_hand);
    logic       adc;
    int         hb, n, nd, dc, di, glitch, serr, merr, p;
    logic [9:0] dexp, dgot;
    logic [7:0] cexp, cgot, cmdgot;
    logic [3:0] t1, t2;
    logic       ln[0:699];
    logic       bz[0:699];
    logic       dn[0:699];
    logic       hv[0:83];
    adc  = ~c[7] && (c[6:0] == 7'h1f);
    hb   = adc ? 84 : 80;
    n    = hb * EXT;
    nd   = adc ? 10 : 8;
    dexp = adc ? a : {2'b00, d};
    cexp = crc_model(c, dexp, nd) ^ {7'b0, inj};

    @(negedge clk);
    req = 1'b1; cmd = c; data = d; adcd = a; crc_inj = inj;
    @(posedge clk);
    #1 req = 1'b0;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      ln[i] = line; bz[i] = busy; dn[i] = done;
      if (i == second_at) begin
        req = 1'b1; cmd = 8'h1f; data = 8'hff; adcd = 10'h3ff;
      end else if (i == second_at + 1) begin
        req = 1'b0;
      end
    end

    chk({nm, "_line_at_accept"}, 32'(ln[0]), 32'd0);
    chk({nm, "_busy_after_accept"}, 32'(bz[0]), 32'd1);
    dc = 0; di = -1;
    for (int i = 0; i < n + 3; i++)
      if (dn[i] === 1'b1) begin
        dc++;
        if (di < 0) di = i;
      end
    chk({nm, "_done_count"}, 32'(dc), 32'd1);
    chk({nm, "_done_cycle"}, 32'(di), 32'(n));
    chk({nm, "_busy_last"}, 32'(bz[n-1]), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(bz[n]), 32'd0);
    chk({nm, "_line_at_done"}, 32'(ln[n]), 32'd0);
    chk({nm, "_line_idle"}, 32'(ln[n+2]), 32'd0);

    glitch = 0;
    for (int h = 0; h < hb; h++) begin
      hv[h] = ln[1 + h*EXT];
      for (int k = 1; k < EXT; k++)
        if (ln[1 + h*EXT + k] !== hv[h]) glitch++;
    end
    chk({nm, "_halfbit_stable"}, 32'(glitch), 32'd0);

    serr = 0;
    for (int h = 0; h < 24; h++)
      if (hv[h] !== ((h % 2) == 0)) serr++;
    chk({nm, "_sync_head"}, 32'(serr), 32'd0);
    t1 = {hv[24], hv[25], hv[26], hv[27]};
    chk({nm, "_sync_tail"}, 32'(t1), 32'hc);

    merr = 0; p = 28;
    cmdgot = '0; dgot = '0; cgot = '0;
    for (int i = 0; i < 8; i++) begin
      if (hv[p] === hv[p+1]) merr++;
      cmdgot = {cmdgot[6:0], hv[p+1]}; p += 2;
    end
    for (int i = 0; i < nd; i++) begin
      if (hv[p] === hv[p+1]) merr++;
      dgot = {dgot[8:0], hv[p+1]}; p += 2;
    end
    for (int i = 0; i < 8; i++) begin
      if (hv[p] === hv[p+1]) merr++;
      cgot = {cgot[6:0], hv[p+1]}; p += 2;
    end
    t2 = {hv[p], hv[p+1], hv[p+2], hv[p+3]};
    chk({nm, "_manchester_valid"}, 32'(merr), 32'd0);
    chk({nm, "_cmd"}, 32'(cmdgot), 32'(c));
    chk({nm, "_data"}, 32'(dgot), 32'(dexp));
    chk({nm, "_crc"}, 32'(cgot), 32'(cexp));
    if (use_hand) chk({nm, "_crc_hand"}, 32'(cgot), 32'(crc_hand));
    chk({nm, "_end_tail"}, 32'(t2), 32'hc);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; req = 1'b0; cmd = '0; data = '0; adcd = '0; crc_inj = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_line", 32'(line), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Write frame, CRC hand-computed as 0x43.
    run_frame("t1_write", 8'h85, 8'h3c, 10'h000, 1'b0, -1, 8'h43, 1'b1);
    // ADC read frame, 10 data bits.
    run_frame("t2_adc", 8'h1f, 8'h00, 10'h2a5, 1'b0, -1, 8'h00, 1'b0);
    // All-zero frame, CRC field zero.
    run_frame("t3_zero", 8'h00, 8'h00, 10'h000, 1'b0, -1, 8'h00, 1'b1);
    // Request while busy is ignored.
    run_frame("t4_busy_req", 8'h85, 8'h3c, 10'h000, 1'b0, 10, 8'h43, 1'b1);

    // Reset mid-frame at half-bit 30.
    @(negedge clk);
    req = 1'b1; cmd = 8'h85; data = 8'h3c; adcd = '0;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (1 + 30*EXT) @(negedge clk);
    chk("t5_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_line_after_rst", 32'(line), 32'd0);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_done_after_rst", 32'(done), 32'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || line === 1'b1) dcnt++;
    end
    chk("t5_quiet_after_rst", 32'(dcnt), 32'd0);
    run_frame("t5_after_rst", 8'h85, 8'h3c, 10'h000, 1'b0, -1, 8'h43, 1'b1);

`ifdef OWT_TX_CRC_ERR_INJ_EN
    run_frame("t6_crc_inj", 8'h00, 8'h00, 10'h000, 1'b1, -1, 8'h01, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
